// File: rtl/seconds_display_pkg.sv
// -----------------------------------------------------------------------------
// seconds_display_pkg
// Shared types and constants for the seconds display and later display stages
// (for example a minutes stage).
//   bcd_t        : one BCD digit (4 bits)
//   seg_t        : 7-segment vector, bit 6 = g ... bit 0 = a
//   SEG_TABLE    : active-high segment patterns for digits 0..9
//   SEG_OFF      : active-high all-segments-off pattern
//   seg_polarity : maps an active-high pattern onto the output polarity
//   seg_blank    : all segments off, in the requested polarity
// -----------------------------------------------------------------------------
package seconds_display_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // Standard hex 7-seg patterns, active-high, ordered g..a.
    localparam seg_t SEG_TABLE [10] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    localparam seg_t SEG_OFF = 7'b0000000;

    function automatic seg_t seg_polarity(input seg_t pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

    function automatic seg_t seg_blank(input bit active_low);
        return seg_polarity(SEG_OFF, active_low);
    endfunction

endpackage

// File: rtl/seconds_display_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD-to-7-segment decoder. Codes 10..15 cannot occur in a BCD
// counter; they decode to all segments off.
// Parameters:
//   SEG_ACTIVE_LOW : 1 = lit segment drives 0, 0 = lit segment drives 1
// Ports:
//   digit : input  BCD digit
//   seg   : output segment vector g..a
// -----------------------------------------------------------------------------
module seg7_decode
    import seconds_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t digit,
    output seg_t seg
);

    seg_t pattern;

    always_comb begin
        pattern = SEG_OFF;
        if (digit <= 4'd9) begin
            pattern = SEG_TABLE[digit];
        end
    end

    assign seg = seg_polarity(pattern, SEG_ACTIVE_LOW);

endmodule

// File: rtl/seconds_display.sv
// -----------------------------------------------------------------------------
// seconds_display
// Counts seconds 00..(MOD_TENS-1)9 in BCD from the edges of the divider's
// 1 Hz toggling output and drives two registered 7-segment digits. A one-cycle
// wrap pulse marks the roll-over to 00 for a downstream minutes stage.
// Optional build macro SECONDS_DISPLAY_BLANK_EN: blank the tens digit while it
// is zero (leading-zero suppression); units are never blanked.
// Parameters:
//   MOD_TENS       : tens-digit modulus, 1..10
//   SEG_ACTIVE_LOW : segment output polarity
// Ports:
//   clock     : input  system clock (divider domain)
//   reset     : input  synchronous active-high reset
//   toggle_in : input  toggling level; every edge is one tick
//   run       : input  1 = count ticks, 0 = ticks dropped
//   clear     : input  synchronous level-sensitive count clear
//   sec_units : output BCD units digit
//   sec_tens  : output BCD tens digit
//   seg_units : output segments for sec_units (one cycle behind the count)
//   seg_tens  : output segments for sec_tens (one cycle behind the count)
//   wrap      : output one-cycle pulse coincident with the count showing 00
// -----------------------------------------------------------------------------
module seconds_display
    import seconds_display_pkg::*;
#(
    parameter int MOD_TENS       = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic toggle_in,
    input  logic run,
    input  logic clear,
    output bcd_t sec_units,
    output bcd_t sec_tens,
    output seg_t seg_units,
    output seg_t seg_tens,
    output logic wrap
);

    localparam bcd_t TENS_MAX  = bcd_t'(MOD_TENS - 1);
    localparam seg_t SEG_ZERO  = seg_polarity(SEG_TABLE[0], SEG_ACTIVE_LOW);
    localparam seg_t SEG_BLANK = seg_blank(SEG_ACTIVE_LOW);

    logic toggle_prev;
    logic tick;
    seg_t units_decoded;
    seg_t tens_decoded;
    seg_t tens_shown;

    // Any level change of toggle_in is one elapsed second.
    assign tick = toggle_in ^ toggle_prev;

    // Stage 1: edge history and BCD count
    always_ff @(posedge clock) begin
        // Tracked unconditionally so held or cleared periods never leave a
        // stale edge behind; reset loads the live level to avoid a false tick.
        toggle_prev <= toggle_in;
        if (reset) begin
            sec_units <= '0;
            sec_tens  <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                sec_units <= '0;
                sec_tens  <= '0;
            end else if (tick && run) begin
                if (sec_units < 4'd9) begin
                    sec_units <= sec_units + 4'd1;
                end else begin
                    sec_units <= '0;
                    if (sec_tens < TENS_MAX) begin
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_tens <= '0;
                        wrap     <= 1'b1;
                    end
                end
            end
        end
    end

    seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_units (
        .digit (sec_units),
        .seg   (units_decoded)
    );

    seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_tens (
        .digit (sec_tens),
        .seg   (tens_decoded)
    );

`ifdef SECONDS_DISPLAY_BLANK_EN
    assign tens_shown = (sec_tens == 4'd0) ? SEG_BLANK : tens_decoded;
`else
    assign tens_shown = tens_decoded;
`endif

    // Stage 2: registered segment outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_units <= SEG_ZERO;
`ifdef SECONDS_DISPLAY_BLANK_EN
            seg_tens  <= SEG_BLANK;
`else
            seg_tens  <= SEG_ZERO;
`endif
        end else begin
            seg_units <= units_decoded;
            seg_tens  <= tens_shown;
        end
    end

endmodule

// File: tb/tb_seconds_display.sv
module tb_seconds_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       toggle_in = 1'b1;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [6:0] seg_units;
    logic [6:0] seg_tens;
    logic       wrap;

    seconds_display #(.MOD_TENS(6), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .toggle_in (toggle_in),
        .run       (run),
        .clear     (clear),
        .sec_units (sec_units),
        .sec_tens  (sec_tens),
        .seg_units (seg_units),
        .seg_tens  (seg_tens),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] units;
        logic [3:0] tens;
        logic       wrap;
        logic [6:0] segu;
        logic [6:0] segt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int wrap_seen = 0;

    logic [3:0] m_units = '0;
    logic [3:0] m_tens  = '0;
    logic       m_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Active-low patterns g..a written out independently of the RTL table.
    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_tens_seg(input logic [3:0] d);
`ifdef SECONDS_DISPLAY_BLANK_EN
        if (d == 4'd0) return 7'h7F;
`endif
        return exp_seg(d);
    endfunction

    // One clock: predict the post-edge outputs from the current inputs, queue
    // them, let the edge happen, then compare against the head of the queue.
    task automatic cycle();
        exp_t e;
        exp_t got;
        logic tick;
        tick   = toggle_in ^ m_prev;
        e.segu = exp_seg(m_units);
        e.segt = exp_tens_seg(m_tens);
        e.units = m_units;
        e.tens  = m_tens;
        e.wrap  = 1'b0;
        if (reset) begin
            e.units = 0; e.tens = 0;
            e.segu = exp_seg(0); e.segt = exp_tens_seg(0);
        end else if (clear) begin
            e.units = 0; e.tens = 0;
        end else if (tick && run) begin
            if (m_units == 4'd9) begin
                e.units = 0;
                if (m_tens == 4'd5) begin
                    e.tens = 0;
                    e.wrap = 1'b1;
                end else begin
                    e.tens = m_tens + 4'd1;
                end
            end else begin
                e.units = m_units + 4'd1;
            end
        end
        sb.push_back(e);
        m_prev  = toggle_in;
        m_units = e.units;
        m_tens  = e.tens;
        @(posedge clock);
        #1;
        if (wrap) wrap_seen++;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("units", 32'(sec_units), 32'(got.units));
            chk("tens", 32'(sec_tens), 32'(got.tens));
            chk("wrap", 32'(wrap), 32'(got.wrap));
            chk("seg_units", 32'(seg_units), 32'(got.segu));
            chk("seg_tens", 32'(seg_tens), 32'(got.segt));
        end
    endtask

    task automatic toggles(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            toggle_in = ~toggle_in;
            for (int j = 0; j < gap; j++) cycle();
        end
    endtask

    initial begin
        // 1: reset with toggle_in held high, then idle
        reset = 1'b1; toggle_in = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        wrap_seen = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("p1_units", 32'(sec_units), 0);
        chk("p1_seg_units", 32'(seg_units), 32'h40);
`ifdef SECONDS_DISPLAY_BLANK_EN
        chk("p1_seg_tens", 32'(seg_tens), 32'h7F);
`else
        chk("p1_seg_tens", 32'(seg_tens), 32'h40);
`endif
        chk("p1_wrap_seen", 32'(wrap_seen), 0);

        // 2: 23 ticks spaced 4 cycles apart
        run = 1'b1;
        toggles(23, 4);
        chk("p2_tens", 32'(sec_tens), 2);
        chk("p2_units", 32'(sec_units), 3);

        // 3: up to 58, then 59, roll-over, and 01
        toggles(35, 2);
        chk("p3_58", 32'({sec_tens, sec_units}), 32'h58);
        toggles(1, 4);
        chk("p3_59", 32'({sec_tens, sec_units}), 32'h59);
        wrap_seen = 0;
        toggles(1, 4);
        chk("p3_wrap_cnt", 32'(wrap_seen), 1);
        toggles(1, 4);
        chk("p3_01", 32'({sec_tens, sec_units}), 32'h01);

        // 4: ticks while run=0 are dropped
        run = 1'b0;
        toggles(5, 2);
        run = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("p4_held", 32'({sec_tens, sec_units}), 32'h01);
        toggles(1, 4);
        chk("p4_02", 32'({sec_tens, sec_units}), 32'h02);

        // 5: clear coincident with a tick at 37
        toggles(35, 2);
        chk("p5_37", 32'({sec_tens, sec_units}), 32'h37);
        wrap_seen = 0;
        toggle_in = ~toggle_in;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        chk("p5_cleared", 32'({sec_tens, sec_units}), 32'h00);
        chk("p5_no_wrap", 32'(wrap_seen), 0);
        toggles(1, 4);
        chk("p5_01", 32'({sec_tens, sec_units}), 32'h01);

        // 6: tens display at 07 and 10
        toggles(6, 4);
        chk("p6_07", 32'({sec_tens, sec_units}), 32'h07);
`ifdef SECONDS_DISPLAY_BLANK_EN
        chk("p6_seg_tens_07", 32'(seg_tens), 32'h7F);
`else
        chk("p6_seg_tens_07", 32'(seg_tens), 32'h40);
`endif
        toggles(3, 4);
        chk("p6_10", 32'({sec_tens, sec_units}), 32'h10);
        chk("p6_seg_tens_10", 32'(seg_tens), 32'h79);
        chk("p6_seg_units_10", 32'(seg_units), 32'h40);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
